// File: rtl/fpu_req_dispatcher.sv
// Shares one FPU among NUM_CH requesters: round-robin request arbitration, tag-routed
// per-channel response FIFOs, and credits that keep the FPU result port free of back-pressure.
module fpu_req_dispatcher_chk #(
   parameter int NUM_CH = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NUM_CH-1:0] inv_ok_i
);
   // credit + outstanding + buffered must always sum to DEPTH on every channel
   a_credit_conservation: assert property (@(posedge clk_i) disable iff (rst_i) (&inv_ok_i));
endmodule

module fpu_req_dispatcher #(
   parameter int WIDTH        = 16,
   parameter int NUM_OPERANDS = 3,
   parameter int NUM_CH       = 4,
   parameter int DEPTH        = 4,
   parameter int TAG_W        = $clog2(NUM_CH)
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic [NUM_CH-1:0]                ch_req_valid_i,
   output logic [NUM_CH-1:0]                ch_req_ready_o,
   input  logic [NUM_CH*NUM_OPERANDS*WIDTH-1:0] ch_operands_i,
   input  logic [NUM_CH*4-1:0]              ch_op_i,
   input  logic [NUM_CH*3-1:0]              ch_rnd_i,
   output logic [NUM_CH-1:0]                ch_rsp_valid_o,
   input  logic [NUM_CH-1:0]                ch_rsp_ready_i,
   output logic [NUM_CH*WIDTH-1:0]          ch_result_o,
   output logic [NUM_CH*5-1:0]              ch_status_o,
   output logic                             fpu_in_valid_o,
   input  logic                             fpu_in_ready_i,
   output logic [NUM_OPERANDS*WIDTH-1:0]    fpu_operands_o,
   output logic [3:0]                       fpu_op_o,
   output logic [2:0]                       fpu_rnd_o,
   output logic [TAG_W-1:0]                 fpu_tag_o,
   input  logic                             fpu_out_valid_i,
   output logic                             fpu_out_ready_o,
   input  logic [WIDTH-1:0]                 fpu_result_i,
   input  logic [4:0]                       fpu_status_i,
   input  logic [TAG_W-1:0]                 fpu_tag_i,
   output logic                             busy_o,
   output logic                             err_tag_o
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OPS_W = NUM_OPERANDS * WIDTH;
   localparam int ENT_W = WIDTH + 5;

   function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   logic [CNT_W-1:0]  r_credit [NUM_CH];
   logic [CNT_W-1:0]  r_outst  [NUM_CH];
   logic [CNT_W-1:0]  r_count  [NUM_CH];
   logic [PTR_W-1:0]  r_wptr   [NUM_CH];
   logic [PTR_W-1:0]  r_rptr   [NUM_CH];
   logic [ENT_W-1:0]  r_mem    [NUM_CH][DEPTH];
   logic [TAG_W-1:0]  r_rr_ptr;
   logic              r_err_tag;

   logic [NUM_CH-1:0] w_elig;
   logic [NUM_CH-1:0] w_gnt;
   logic [NUM_CH-1:0] w_acc;
   logic [NUM_CH-1:0] w_push;
   logic [NUM_CH-1:0] w_pop;
   logic [NUM_CH-1:0] w_tag_hit;
   logic [NUM_CH-1:0] w_rsp_valid;
   logic [NUM_CH-1:0] w_inv_ok;
   logic [TAG_W-1:0]  w_gnt_idx;
   logic [TAG_W-1:0]  w_scan_idx;
   logic              w_any;
   logic              w_busy;

   // Per-channel eligibility, result routing and FIFO pop decode
   always_comb begin
      w_elig      = '0;
      w_tag_hit   = '0;
      w_rsp_valid = '0;
      w_pop       = '0;
      w_push      = '0;
      w_busy      = 1'b0;
      w_inv_ok    = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         w_elig[c]      = !rst_i && ch_req_valid_i[c] && (r_credit[c] != '0);
         w_tag_hit[c]   = (fpu_tag_i == TAG_W'(c));
         w_rsp_valid[c] = !rst_i && (r_count[c] != '0);
         w_pop[c]       = w_rsp_valid[c] && ch_rsp_ready_i[c];
         w_push[c]      = !rst_i && fpu_out_valid_i && w_tag_hit[c] && (r_outst[c] != '0);
         w_busy         = w_busy | (r_credit[c] != CNT_W'(DEPTH));
         w_inv_ok[c]    = ({2'b00, r_credit[c]} + {2'b00, r_outst[c]} + {2'b00, r_count[c]})
                          == (CNT_W + 2)'(DEPTH);
      end
   end

   // Round-robin search: first eligible channel at or after the pointer
   always_comb begin
      w_any      = 1'b0;
      w_gnt_idx  = '0;
      w_scan_idx = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_scan_idx = TAG_W'((int'(r_rr_ptr) + i) % NUM_CH);
         if (!w_any && w_elig[w_scan_idx]) begin
            w_any     = 1'b1;
            w_gnt_idx = w_scan_idx;
         end else begin
            w_any     = w_any;
         end
      end
   end

   // Granted channel drives the FPU request buses (grant is one-hot, so AND-OR mux)
   always_comb begin
      w_gnt          = '0;
      w_acc          = '0;
      fpu_operands_o = '0;
      fpu_op_o       = 4'b0000;
      fpu_rnd_o      = 3'b000;
      for (int c = 0; c < NUM_CH; c++) begin
         w_gnt[c]       = w_any && (w_gnt_idx == TAG_W'(c));
         w_acc[c]       = w_gnt[c] && fpu_in_ready_i;
         fpu_operands_o = fpu_operands_o | ({OPS_W{w_gnt[c]}} & ch_operands_i[c*OPS_W +: OPS_W]);
         fpu_op_o       = fpu_op_o  | ({4{w_gnt[c]}} & ch_op_i[c*4 +: 4]);
         fpu_rnd_o      = fpu_rnd_o | ({3{w_gnt[c]}} & ch_rnd_i[c*3 +: 3]);
      end
   end

   // Response heads, zeroed while a channel has nothing to offer
   always_comb begin
      ch_result_o = '0;
      ch_status_o = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         ch_result_o[c*WIDTH +: WIDTH] = {WIDTH{w_rsp_valid[c]}} & r_mem[c][r_rptr[c]][WIDTH-1:0];
         ch_status_o[c*5 +: 5]         = {5{w_rsp_valid[c]}} & r_mem[c][r_rptr[c]][ENT_W-1:WIDTH];
      end
   end

   assign ch_req_ready_o  = w_acc;
   assign fpu_in_valid_o  = w_any;
   assign fpu_tag_o       = w_gnt_idx;
   assign fpu_out_ready_o = !rst_i;
   assign ch_rsp_valid_o  = w_rsp_valid;
   assign busy_o          = !rst_i && w_busy;
   assign err_tag_o       = r_err_tag;

   // Credit/outstanding/occupancy counters, FIFO pointers, RR pointer, sticky tag error
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int c = 0; c < NUM_CH; c++) begin
            r_credit[c] <= CNT_W'(DEPTH);
            r_outst[c]  <= '0;
            r_count[c]  <= '0;
            r_wptr[c]   <= '0;
            r_rptr[c]   <= '0;
         end
         r_rr_ptr  <= '0;
         r_err_tag <= 1'b0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            r_credit[c] <= r_credit[c] - CNT_W'(w_acc[c]) + CNT_W'(w_pop[c]);
            r_outst[c]  <= r_outst[c] + CNT_W'(w_acc[c]) - CNT_W'(w_push[c]);
            r_count[c]  <= r_count[c] + CNT_W'(w_push[c]) - CNT_W'(w_pop[c]);
            if (w_push[c]) r_wptr[c] <= f_ptr_inc(r_wptr[c]);
            if (w_pop[c])  r_rptr[c] <= f_ptr_inc(r_rptr[c]);
         end
         if (w_any && fpu_in_ready_i)
            r_rr_ptr <= (w_gnt_idx == TAG_W'(NUM_CH - 1)) ? '0 : w_gnt_idx + TAG_W'(1);
         if (fpu_out_valid_i && (w_push == '0))
            r_err_tag <= 1'b1;
      end
   end

   // FIFO storage, written at the tail of the tagged channel
   always_ff @(posedge clk_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
         if (w_push[c]) r_mem[c][r_wptr[c]] <= {fpu_status_i, fpu_result_i};
      end
   end

   fpu_req_dispatcher_chk #(.NUM_CH(NUM_CH)) u_chk (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .inv_ok_i (w_inv_ok)
   );
endmodule

// File: tb/tb_fpu_req_dispatcher.sv
// Bench for fpu_req_dispatcher: plays the four requesters and the FPU, and checks every
// cycle against a queue-based model of credits, in-flight results and response FIFOs.
module tb_fpu_req_dispatcher;
   localparam int W = 16, NOP = 3, NCH = 4, DEP = 4, TW = 2;

   logic               clk_i = 1'b0;
   logic               rst_i;
   logic [NCH-1:0]     ch_req_valid_i, ch_req_ready_o, ch_rsp_valid_o, ch_rsp_ready_i;
   logic [NCH*NOP*W-1:0] ch_operands_i;
   logic [NCH*4-1:0]   ch_op_i;
   logic [NCH*3-1:0]   ch_rnd_i;
   logic [NCH*W-1:0]   ch_result_o;
   logic [NCH*5-1:0]   ch_status_o;
   logic               fpu_in_valid_o, fpu_in_ready_i, fpu_out_valid_i, fpu_out_ready_o;
   logic [NOP*W-1:0]   fpu_operands_o;
   logic [3:0]         fpu_op_o;
   logic [2:0]         fpu_rnd_o;
   logic [TW-1:0]      fpu_tag_o, fpu_tag_i;
   logic [W-1:0]       fpu_result_i;
   logic [4:0]         fpu_status_i;
   logic               busy_o, err_tag_o;

   fpu_req_dispatcher #(.WIDTH(W), .NUM_OPERANDS(NOP), .NUM_CH(NCH), .DEPTH(DEP)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .ch_req_valid_i(ch_req_valid_i), .ch_req_ready_o(ch_req_ready_o),
      .ch_operands_i(ch_operands_i), .ch_op_i(ch_op_i), .ch_rnd_i(ch_rnd_i),
      .ch_rsp_valid_o(ch_rsp_valid_o), .ch_rsp_ready_i(ch_rsp_ready_i),
      .ch_result_o(ch_result_o), .ch_status_o(ch_status_o),
      .fpu_in_valid_o(fpu_in_valid_o), .fpu_in_ready_i(fpu_in_ready_i),
      .fpu_operands_o(fpu_operands_o), .fpu_op_o(fpu_op_o), .fpu_rnd_o(fpu_rnd_o),
      .fpu_tag_o(fpu_tag_o), .fpu_out_valid_i(fpu_out_valid_i), .fpu_out_ready_o(fpu_out_ready_o),
      .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i), .fpu_tag_i(fpu_tag_i),
      .busy_o(busy_o), .err_tag_o(err_tag_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed { logic [1:0] tag; logic [15:0] res; logic [4:0] st; } fl_t;

   int n_vec = 0, n_miss = 0;
   int m_credit [NCH];
   int m_ptr;
   bit m_err;
   logic [20:0] m_q [NCH][16];
   int m_qh [NCH];
   int m_qn [NCH];
   fl_t fl [$];

   bit          req_pend [NCH];
   logic [47:0] req_ops  [NCH];
   logic [3:0]  req_op   [NCH];
   logic [2:0]  req_rnd  [NCH];

   logic [3:0] want, rsp_rdy, last_ready;
   logic [1:0] last_tag, inj_tag;
   bit         in_rdy, inj_en, last_valid;
   int         ret_prob;
   int         cnt, cnt2;

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_credit[c] = DEP; m_qh[c] = 0; m_qn[c] = 0; req_pend[c] = 1'b0;
      end
      m_ptr = 0; m_err = 1'b0;
      fl.delete();
   endtask

   task automatic do_reset();
      rst_i = 1'b1; ch_req_valid_i = 4'hF; ch_rsp_ready_i = 4'h0; fpu_in_ready_i = 1'b1;
      ch_operands_i = '0; ch_op_i = '0; ch_rnd_i = '0;
      fpu_out_valid_i = 1'b0; fpu_tag_i = 2'd0; fpu_result_i = 16'h0000; fpu_status_i = 5'h00;
      tick(); tick();
      chk("rst_req_ready", ch_req_ready_o, 4'h0);
      chk("rst_in_valid", fpu_in_valid_o, 1'b0);
      chk("rst_out_ready", fpu_out_ready_o, 1'b0);
      chk("rst_rsp_valid", ch_rsp_valid_o, 4'h0);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_err", err_tag_o, 1'b0);
      rst_i = 1'b0; ch_req_valid_i = 4'h0;
      model_reset();
      #1;
      chk("post_rst_out_ready", fpu_out_ready_o, 1'b1);
      chk("post_rst_busy", busy_o, 1'b0);
      chk("post_rst_rsp_valid", ch_rsp_valid_o, 4'h0);
      tick();
   endtask

   task automatic one_cycle();
      int g, idx, k;
      bit ret, anyb;
      fl_t r;
      logic [63:0] rnd64;
      for (int c = 0; c < NCH; c++) begin
         if (!req_pend[c] && want[c]) begin
            rnd64 = {$urandom(), $urandom()};
            req_pend[c] = 1'b1; req_ops[c] = rnd64[47:0];
            req_op[c] = 4'($urandom_range(0, 15)); req_rnd[c] = 3'($urandom_range(0, 4));
         end
         ch_req_valid_i[c] = req_pend[c];
         ch_operands_i[c*48 +: 48] = req_ops[c];
         ch_op_i[c*4 +: 4] = req_op[c];
         ch_rnd_i[c*3 +: 3] = req_rnd[c];
      end
      ch_rsp_ready_i = rsp_rdy; fpu_in_ready_i = in_rdy;
      ret = 1'b0; r = '0;
      if (inj_en) begin
         fpu_out_valid_i = 1'b1; fpu_tag_i = inj_tag; fpu_result_i = 16'hDEAD; fpu_status_i = 5'h1F;
      end else if (fl.size() > 0 && $urandom_range(0, 99) < ret_prob) begin
         ret = 1'b1; r = fl[0];
         fpu_out_valid_i = 1'b1; fpu_tag_i = r.tag; fpu_result_i = r.res; fpu_status_i = r.st;
      end else begin
         fpu_out_valid_i = 1'b0;
      end
      #1;
      g = -1;
      for (int i = 0; i < NCH; i++) begin
         idx = (m_ptr + i) % NCH;
         if (g < 0 && req_pend[idx] && m_credit[idx] > 0) g = idx;
      end
      chk("in_valid", fpu_in_valid_o, g >= 0);
      chk("req_ready", ch_req_ready_o, (g >= 0 && in_rdy) ? (1 << g) : 0);
      if (g >= 0) begin
         chk("fpu_tag", fpu_tag_o, g);
         chk("fpu_operands", fpu_operands_o, req_ops[g]);
         chk("fpu_op_rnd", {fpu_op_o, fpu_rnd_o}, {req_op[g], req_rnd[g]});
      end
      anyb = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         chk("rsp_valid", ch_rsp_valid_o[c], m_qn[c] > 0);
         if (m_qn[c] > 0)
            chk("rsp_data", {ch_status_o[c*5 +: 5], ch_result_o[c*16 +: 16]}, m_q[c][m_qh[c]]);
         if (m_credit[c] != DEP) anyb = 1'b1;
      end
      chk("busy", busy_o, anyb);
      chk("err_tag", err_tag_o, m_err);
      last_ready = ch_req_ready_o; last_tag = fpu_tag_o; last_valid = fpu_in_valid_o;
      for (int c = 0; c < NCH; c++) begin
         if (m_qn[c] > 0 && rsp_rdy[c]) begin
            m_qh[c] = (m_qh[c] + 1) % 16; m_qn[c]--; m_credit[c]++;
         end
      end
      if (g >= 0 && in_rdy) begin
         m_credit[g]--;
         fl.push_back({2'(g), req_ops[g][15:0] + req_ops[g][31:16], 5'($urandom_range(0, 31))});
         req_pend[g] = 1'b0;
         m_ptr = (g + 1) % NCH;
      end
      if (ret) begin
         void'(fl.pop_front());
         m_q[r.tag][(m_qh[r.tag] + m_qn[r.tag]) % 16] = {r.st, r.res};
         m_qn[r.tag]++;
      end
      if (inj_en) begin
         k = 0;
         foreach (fl[j]) if (fl[j].tag == inj_tag) k++;
         if (k == 0) m_err = 1'b1;
      end
      tick();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) one_cycle();
   endtask

   initial begin
      want = 4'h0; rsp_rdy = 4'h0; in_rdy = 1'b1; ret_prob = 100; inj_en = 1'b0; inj_tag = 2'd0;
      do_reset();

      // single ADD 1.0 + 1.0 on channel 0
      ch_req_valid_i = 4'b0001;
      ch_operands_i[47:0] = {16'h0000, 16'h3C00, 16'h3C00};
      ch_op_i[3:0] = 4'd2; ch_rnd_i[2:0] = 3'd0; fpu_in_ready_i = 1'b1; ch_rsp_ready_i = 4'h0;
      #1;
      chk("t1_req_ready", ch_req_ready_o, 4'b0001);
      chk("t1_in_valid", fpu_in_valid_o, 1'b1);
      chk("t1_tag", fpu_tag_o, 2'd0);
      chk("t1_operands", fpu_operands_o, 48'h0000_3C00_3C00);
      chk("t1_op", fpu_op_o, 4'd2);
      tick();
      ch_req_valid_i = 4'h0;
      #1;
      chk("t1_busy", busy_o, 1'b1);
      chk("t1_ready_drop", ch_req_ready_o, 4'h0);
      fpu_out_valid_i = 1'b1; fpu_tag_i = 2'd0; fpu_result_i = 16'h4000; fpu_status_i = 5'h00;
      #1;
      chk("t1_rsp_not_yet", ch_rsp_valid_o, 4'h0);
      tick();
      fpu_out_valid_i = 1'b0;
      #1;
      chk("t1_rsp_valid", ch_rsp_valid_o, 4'b0001);
      chk("t1_result", ch_result_o[15:0], 16'h4000);
      chk("t1_status", ch_status_o[4:0], 5'h00);
      ch_rsp_ready_i = 4'b0001;
      tick();
      ch_rsp_ready_i = 4'h0;
      #1;
      chk("t1_rsp_popped", ch_rsp_valid_o, 4'h0);
      chk("t1_idle", busy_o, 1'b0);
      do_reset();

      // all channels requesting: strict rotation from channel 0
      want = 4'hF; rsp_rdy = 4'hF; in_rdy = 1'b1; ret_prob = 100;
      for (int i = 0; i < 8; i++) begin
         one_cycle();
         chk("rr_valid", last_valid, 1'b1);
         chk("rr_order", last_tag, i % NCH);
      end

      // channel 2 stops draining: it runs out of credit, others keep going
      rsp_rdy = 4'b1011;
      run(30);
      cnt = 0; cnt2 = 0;
      for (int i = 0; i < 6; i++) begin
         one_cycle();
         cnt += int'(last_ready[2]);
         cnt2 += int'(|last_ready);
      end
      chk("ch2_starved", cnt, 0);
      chk("others_granted", cnt2, 6);
      rsp_rdy = 4'hF;
      one_cycle();
      rsp_rdy = 4'b1011;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         one_cycle();
         cnt += int'(last_ready[2]);
      end
      chk("ch2_one_grant", cnt, 1);

      // FPU stalls with only channel 1 requesting
      want = 4'h0; rsp_rdy = 4'hF;
      run(20);
      want = 4'b0010; in_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         one_cycle();
         chk("stall_ready", last_ready, 4'h0);
         chk("stall_tag", last_tag, 2'd1);
      end
      in_rdy = 1'b1;
      one_cycle();
      chk("stall_release", last_ready, 4'b0010);
      want = 4'h0;

      // stray result on an idle channel
      run(20);
      inj_en = 1'b1; inj_tag = 2'd3;
      one_cycle();
      inj_en = 1'b0;
      run(3);
      chk("err_sticky", err_tag_o, 1'b1);
      chk("err_dropped", ch_rsp_valid_o[3], 1'b0);

      // reset with two results buffered on channel 0
      rsp_rdy = 4'h0; want = 4'b0001;
      run(2);
      want = 4'h0;
      run(3);
      chk("buf_two", m_qn[0], 2);
      chk("buf_valid", ch_rsp_valid_o[0], 1'b1);
      chk("buf_busy", busy_o, 1'b1);
      do_reset();
      chk("rst_err_cleared", err_tag_o, 1'b0);
      want = 4'b0001; rsp_rdy = 4'h0; ret_prob = 100;
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         one_cycle();
         cnt += int'(last_ready[0]);
      end
      chk("credits_restored", cnt, DEP);

      // randomized traffic
      ret_prob = 60;
      for (int i = 0; i < 1500; i++) begin
         want = 4'($urandom_range(0, 15));
         rsp_rdy = 4'($urandom_range(0, 15));
         in_rdy = ($urandom_range(0, 3) != 0);
         one_cycle();
      end
      want = 4'h0; rsp_rdy = 4'hF; in_rdy = 1'b1; ret_prob = 100;
      run(30);
      chk("final_idle", busy_o, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
